// File: rtl/frame_minmax_tracker.sv
// Per-frame statistics over a 4-bit sample stream: max, min, and rise/fall counts
// between consecutive samples. Each frame result is handed off through a valid/ready hold stage.

module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       a_gt_b,
  output logic       a_lt_b,
  output logic       a_eq_b
);
  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
  assign a_eq_b = (a == b);
endmodule

module frame_minmax_tracker #(
  parameter  int DATA_W    = 4,
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [CNT_W-1:0]  out_rise,
  output logic [CNT_W-1:0]  out_fall
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]  rise_q, rise_d;
  logic [CNT_W-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic [DATA_W-1:0] out_min_q, out_min_d;
  logic [CNT_W-1:0]  out_rise_q, out_rise_d;
  logic [CNT_W-1:0]  out_fall_q, out_fall_d;

  logic              accept;
  logic              xfer;
  logic [DATA_W-1:0] acc_max, acc_min;
  logic [CNT_W-1:0]  acc_rise, acc_fall, acc_idx;

  // Comparator lanes: 0 = running max, 1 = running min, 2 = previous sample
  logic [DATA_W-1:0] cmp_ref [3];
  logic [2:0]        cmp_gt, cmp_lt, cmp_eq;
  logic              unused_cmp;

  assign cmp_ref[0] = max_q;
  assign cmp_ref[1] = min_q;
  assign cmp_ref[2] = prev_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cmp
      comparator_4bit u_cmp (
        .a      (in_data),
        .b      (cmp_ref[gi]),
        .a_gt_b (cmp_gt[gi]),
        .a_lt_b (cmp_lt[gi]),
        .a_eq_b (cmp_eq[gi])
      );
    end
  endgenerate

  // Equality carries no update; only the directional flags drive the datapath.
  assign unused_cmp = ^{cmp_eq, cmp_lt[0], cmp_gt[1]};

  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;
  assign in_ready = (state_q != HOLD);

  assign acc_max  = cmp_gt[0] ? in_data : max_q;
  assign acc_min  = cmp_lt[1] ? in_data : min_q;
  assign acc_rise = rise_q + CNT_W'(cmp_gt[2]);
  assign acc_fall = fall_q + CNT_W'(cmp_lt[2]);
  assign acc_idx  = idx_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    min_d       = min_q;
    prev_d      = prev_q;
    rise_d      = rise_q;
    fall_d      = fall_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    out_rise_d  = out_rise_q;
    out_fall_d  = out_fall_q;

    if (clear) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
      rise_d      = '0;
      fall_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            max_d  = in_data;
            min_d  = in_data;
            prev_d = in_data;
            rise_d = '0;
            fall_d = '0;
            idx_d  = CNT_W'(1);
            if (FRAME_LEN == 1) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_max_d   = in_data;
              out_min_d   = in_data;
              out_rise_d  = '0;
              out_fall_d  = '0;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            max_d  = acc_max;
            min_d  = acc_min;
            prev_d = in_data;
            rise_d = acc_rise;
            fall_d = acc_fall;
            idx_d  = acc_idx;
            // Publish the updated statistics on the same edge that takes the last sample
            if (acc_idx == LAST_IDX) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_max_d   = acc_max;
              out_min_d   = acc_min;
              out_rise_d  = acc_rise;
              out_fall_d  = acc_fall;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      max_q       <= '0;
      min_q       <= '0;
      prev_q      <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_rise_q  <= '0;
      out_fall_q  <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      min_q       <= min_d;
      prev_q      <= prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      out_rise_q  <= out_rise_d;
      out_fall_q  <= out_fall_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_min   = out_min_q;
  assign out_rise  = out_rise_q;
  assign out_fall  = out_fall_q;

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Directed bench for frame_minmax_tracker: hand-computed frame results, backpressure,
// input gaps, clear and asynchronous reset behaviour.

module tb_frame_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [3:0] out_rise;
  logic [3:0] out_fall;

  int tests_run = 0;
  int tests_failed = 0;

  frame_minmax_tracker #(.DATA_W(4), .FRAME_LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_rise  (out_rise),
    .out_fall  (out_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Starts at a negedge, presents one sample across one posedge, ends at the next negedge.
  task automatic push(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sample 0 is the most significant nibble, so 32'h3772_9914 reads in stream order.
  task automatic send_frame(input logic [31:0] v, input int max_gap);
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      push(v[31-4*i -: 4]);
    end
  endtask

  task automatic check_result(input string tag, input int mx, input int mn, input int r, input int f);
    check({tag, ".valid"}, int'(out_valid), 1);
    check({tag, ".max"},   int'(out_max), mx);
    check({tag, ".min"},   int'(out_min), mn);
    check({tag, ".rise"},  int'(out_rise), r);
    check({tag, ".fall"},  int'(out_fall), f);
    check({tag, ".in_ready"}, int'(in_ready), 0);
  endtask

  // With out_ready high the result drains on the next edge.
  task automatic drain(input string tag, input int mx);
    @(negedge clk);
    check({tag, ".drained"}, int'(out_valid), 0);
    check({tag, ".ready_again"}, int'(in_ready), 1);
    check({tag, ".max_kept"}, int'(out_max), mx);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.valid", int'(out_valid), 0);
    check("reset.in_ready", int'(in_ready), 1);
    check("reset.max", int'(out_max), 0);
    check("reset.rise", int'(out_rise), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame with ties, rises and falls
    send_frame(32'h3772_9914, 0);
    check_result("t1", 9, 1, 3, 2);
    drain("t1", 9);

    // Backpressure: result held, inputs ignored
    out_ready = 1'b0;
    send_frame(32'h3772_9914, 0);
    check_result("t2", 9, 1, 3, 2);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 4'hF;
      @(negedge clk);
      check_result($sformatf("t2.hold%0d", c), 9, 1, 3, 2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t2.released", int'(out_valid), 0);
    check("t2.ready_after", int'(in_ready), 1);

    // Next frame begins in the cycle right after the transfer
    send_frame(32'h0123_4567, 0);
    check_result("t3b", 7, 0, 7, 0);
    drain("t3b", 7);

    send_frame(32'hFFFF_FFFF, 0);
    check_result("t3a", 15, 15, 0, 0);
    drain("t3a", 15);

    // Gaps in in_valid must not disturb the result
    send_frame(32'h3772_9914, 2);
    check_result("t4", 9, 1, 3, 2);
    drain("t4", 9);

    // Abort mid-frame; the sample presented with clear is dropped
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd0;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check("t5.no_valid", int'(out_valid), 0);
    check("t5.in_ready", int'(in_ready), 1);
    send_frame(32'h8888_8885, 0);
    check_result("t5", 8, 5, 0, 1);
    drain("t5", 8);

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    send_frame(32'h3772_9914, 0);
    check_result("t6", 9, 1, 3, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst.valid", int'(out_valid), 0);
    check("t6.rst.max", int'(out_max), 0);
    check("t6.rst.min", int'(out_min), 0);
    check("t6.rst.rise", int'(out_rise), 0);
    check("t6.rst.fall", int'(out_fall), 0);
    check("t6.rst.in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clear in HOLD discards the pending result
    send_frame(32'h3772_9914, 0);
    check_result("t6c", 9, 1, 3, 2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t6c.cleared", int'(out_valid), 0);
    check("t6c.in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t6c.stays_clear", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
